// File: rtl/aca_ctrl_pkg.sv
// rtl/aca_ctrl_pkg.sv - shared state encoding and constants for the ACA correction controller
package aca_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPROX,
        ST_CORRECT,
        ST_DONE
    } aca_state_t;

    localparam int NIBBLES           = 8;
    localparam int MAX_LEVEL         = 6;
    localparam int FIRST_CORR_NIBBLE = 2;

endpackage

// File: rtl/aca_window_adder.sv
// rtl/aca_window_adder.sv - combinational 8-bit sliding-window approximate adder
//
// Ports:
//   a, b : 32-bit operands
//   sum  : approximate sum (low byte exact, each higher nibble from an 8-bit window, carry-in 0)
//   cout : approximate carry out (carry of the top byte window only)
module aca_window_adder
    import aca_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        cout
);

    assign sum[7:0] = a[7:0] + b[7:0];

    // Each nibble k is the upper half of the sum of the byte ending at it, so only
    // carries generated inside the preceding nibble are seen.
    for (genvar k = FIRST_CORR_NIBBLE; k < NIBBLES; k++) begin : g_win
        assign sum[4*k+3 -: 4] = 4'((a[4*k+3 -: 8] + b[4*k+3 -: 8]) >> 4);
    end

    assign cout = 1'(({1'b0, a[31:24]} + {1'b0, b[31:24]}) >> 8);

endmodule

// File: rtl/aca_correction_ctrl.sv
// rtl/aca_correction_ctrl.sv - approximate adder with L-cycle nibble-serial carry correction
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : request handshake (ready only when idle)
//   a, b                : 32-bit operands
//   acc_level           : number of correction cycles L (0..6, 7 treated as 6)
//   out_valid/out_ready : result handshake
//   sum, cout           : result and carry out
//   exact               : result guaranteed exact (L == 6)
//   err_fixed           : at least one corrected nibble differed from the approximation
//   err_cnt             : saturating count of delivered results with err_fixed set
//                         (present only when ACA_ERR_CNT_EN is defined)
module aca_correction_ctrl
    import aca_ctrl_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  acc_level,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sum,
    output logic        cout,
    output logic        exact,
    output logic        err_fixed
`ifdef ACA_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    if (ERR_CNT_W < 1) begin : g_bad_width
        $error("ERR_CNT_W must be at least 1");
    end

    aca_state_t  state, state_n;
    logic [31:0] a_q, b_q;
    logic [2:0]  lvl_q;
    logic [2:0]  cnt_q;
    logic [2:0]  k_q;
    logic        c_q;
    logic [2:0]  lvl_clamped;
    logic [31:0] win_sum;
    logic        win_cout;
    logic        byte0_carry;
    logic [4:0]  corr;
    logic [3:0]  old_nib;

    assign lvl_clamped = (acc_level > 3'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : acc_level;
    assign in_ready    = (state == ST_IDLE);
    assign out_valid   = (state == ST_DONE);

    aca_window_adder u_win (
        .a    (a_q),
        .b    (b_q),
        .sum  (win_sum),
        .cout (win_cout)
    );

    // Exact carry into nibble 2 seeds the ripple correction chain.
    assign byte0_carry = 1'(({1'b0, a_q[7:0]} + {1'b0, b_q[7:0]}) >> 8);

    assign old_nib = sum[{k_q, 2'b00} +: 4];
    assign corr    = {1'b0, a_q[{k_q, 2'b00} +: 4]} + {1'b0, b_q[{k_q, 2'b00} +: 4]} + {4'b0, c_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    if (in_valid) state_n = ST_APPROX;
            ST_APPROX:  state_n = (lvl_q == 3'd0) ? ST_DONE : ST_CORRECT;
            ST_CORRECT: if (cnt_q == 3'd1) state_n = ST_DONE;
            ST_DONE:    if (out_ready) state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            lvl_q     <= '0;
            cnt_q     <= '0;
            k_q       <= 3'(FIRST_CORR_NIBBLE);
            c_q       <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            exact     <= 1'b0;
            err_fixed <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q       <= a;
                        b_q       <= b;
                        lvl_q     <= lvl_clamped;
                        exact     <= (lvl_clamped == 3'(MAX_LEVEL));
                        err_fixed <= 1'b0;
                    end
                end
                ST_APPROX: begin
                    sum   <= win_sum;
                    cout  <= win_cout;
                    c_q   <= byte0_carry;
                    k_q   <= 3'(FIRST_CORR_NIBBLE);
                    cnt_q <= lvl_q;
                end
                ST_CORRECT: begin
                    sum[{k_q, 2'b00} +: 4] <= corr[3:0];
                    c_q                    <= corr[4];
                    if (corr[3:0] != old_nib) err_fixed <= 1'b1;
                    k_q   <= k_q + 3'd1;
                    cnt_q <= cnt_q - 3'd1;
                    // Only a full correction chain reaches the top nibble, so only then
                    // is the ripple carry the true carry out.
                    if (cnt_q == 3'd1 && lvl_q == 3'(MAX_LEVEL)) cout <= corr[4];
                end
                default: ;
            endcase
        end
    end

`ifdef ACA_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (state == ST_DONE && out_ready && err_fixed && err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_aca_correction_ctrl.sv
// tb/tb_aca_correction_ctrl.sv - scoreboard testbench for aca_correction_ctrl
module tb_aca_correction_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic [2:0]  acc_level;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout, exact, err_fixed;
`ifdef ACA_ERR_CNT_EN
    logic [1:0]  err_cnt;
    int          model_cnt = 0;
`endif

    aca_correction_ctrl #(.ERR_CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .acc_level (acc_level),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .exact     (exact),
        .err_fixed (err_fixed)
`ifdef ACA_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        exact;
        logic        err;
        int          lat;
        int          stall;
        int          acc_edge;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;
    int   stall_n = 0;
    bit   seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] il,
                         input logic [31:0] es, input logic ec, input logic ee, input logic ef,
                         input int lat, input int stall);
        exp_t e;
        int   n;
        a = ia; b = ib; acc_level = il; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        chk("no_outstanding_at_accept", pushed - popped, 0);
        e.sum = es; e.cout = ec; e.exact = ee; e.err = ef;
        e.lat = lat; e.stall = stall; e.acc_edge = cyc + 1;
        sb.push_back(e);
        pushed++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
    endtask

    // Monitor: pops the oldest expectation whenever a result is handed over.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
                out_ready = 1'b1;
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", cyc - sb[0].acc_edge + 1, sb[0].lat);
                end
                if (stall_n < sb[0].stall) begin
                    out_ready = 1'b0;
                    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("stall_sum", sum, sb[0].sum);
                    stall_n++;
                end else begin
                    out_ready = 1'b1;
                    chk("sum", sum, sb[0].sum);
                    chk("cout", {31'd0, cout}, {31'd0, sb[0].cout});
                    chk("exact", {31'd0, exact}, {31'd0, sb[0].exact});
                    chk("err_fixed", {31'd0, err_fixed}, {31'd0, sb[0].err});
`ifdef ACA_ERR_CNT_EN
                    chk("err_cnt", {30'd0, err_cnt}, model_cnt);
                    if (sb[0].err && model_cnt < 3) model_cnt++;
`endif
                    void'(sb.pop_front());
                    popped++;
                    seen = 1'b0;
                    stall_n = 0;
                end
            end
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        chk("watchdog", 32'd1, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; acc_level = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_exact", {31'd0, exact}, 32'd0);
        chk("rst_err_fixed", {31'd0, err_fixed}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        //    a             b             L     sum           c     ex    err   lat stall
        issue(32'h00000F80, 32'h00000080, 3'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 2, 0);
        issue(32'h00000F80, 32'h00000080, 3'd1, 32'h00000000, 1'b0, 1'b0, 1'b0, 3, 0);
        issue(32'h00000F80, 32'h00000080, 3'd2, 32'h00001000, 1'b0, 1'b0, 1'b1, 4, 0);
        issue(32'hFFFFFFFF, 32'h00000001, 3'd6, 32'h00000000, 1'b1, 1'b1, 1'b1, 8, 0);
        issue(32'hFFFFFFFF, 32'h00000001, 3'd7, 32'h00000000, 1'b1, 1'b1, 1'b1, 8, 0);
        issue(32'h12345678, 32'h11111111, 3'd3, 32'h23456789, 1'b0, 1'b0, 1'b0, 5, 0);
        issue(32'hF0000000, 32'h10000000, 3'd0, 32'h00000000, 1'b1, 1'b0, 1'b0, 2, 0);
        issue(32'hF0000000, 32'h10000000, 3'd6, 32'h00000000, 1'b1, 1'b1, 1'b0, 8, 0);
        // Result held for 5 cycles while the next request waits with in_valid high.
        issue(32'h00000F80, 32'h00000080, 3'd2, 32'h00001000, 1'b0, 1'b0, 1'b1, 4, 5);
        issue(32'h00000005, 32'h00000006, 3'd1, 32'h0000000B, 1'b0, 1'b0, 1'b0, 3, 0);
        drain();

        // Abort an L=6 operation in its third correction cycle.
        a = 32'hFFFFFFFF; b = 32'h00000001; acc_level = 3'd6; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_sum", sum, 32'd0);
        chk("abort_err_fixed", {31'd0, err_fixed}, 32'd0);
        chk("abort_exact", {31'd0, exact}, 32'd0);
`ifdef ACA_ERR_CNT_EN
        model_cnt = 0;
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        issue(32'h00000001, 32'h00000002, 3'd0, 32'h00000003, 1'b0, 1'b0, 1'b0, 2, 0);
        issue(32'h00000F80, 32'h00000080, 3'd2, 32'h00001000, 1'b0, 1'b0, 1'b1, 4, 0);
        drain();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
